// File: rtl/lab_request_queue_pkg.sv
// Shared encodings and the stored-entry layout for the lab request queue.
// The optional pop-time parity filter is enabled by LAB_REQ_PARITY_FILTER_EN.
package lab_request_queue_pkg;

    localparam int CODE_W = 5;

    localparam logic [1:0] MODE_EXIT  = 2'b00;
    localparam logic [1:0] MODE_ENTER = 2'b01;
    localparam logic [1:0] MODE_IDLE  = 2'b10;

    localparam logic LAB_DIGITAL = 1'b0;
    localparam logic LAB_MERA    = 1'b1;

    // One queued request: {code, lab, mode}
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              lab;
        logic [1:0]        mode;
    } entry_t;

    // Enter requests are rejected when the code parity does not match the
    // reader: Digital codes must have even popcount, Mera codes odd popcount.
    function automatic logic parity_drop(input entry_t e);
        return (e.mode == MODE_ENTER) && ((^e.code) != e.lab);
    endfunction

endpackage

// File: rtl/lab_request_queue_if.sv
// Reader, downstream and status signals of the lab request queue.
// The slave modport is the queue itself; master is the environment side.
interface lab_request_queue_if
    import lab_request_queue_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic              digValid;
    logic              digReady;
    logic [CODE_W-1:0] digCode;
    logic [1:0]        digMode;

    logic              meraValid;
    logic              meraReady;
    logic [CODE_W-1:0] meraCode;
    logic [1:0]        meraMode;

    logic              outReady;
    logic [CODE_W-1:0] smartCode;
    logic              lab;
    logic [1:0]        mode;

    logic [$clog2(DEPTH):0] occupancy;
    logic              isFullQ;
    logic              isEmptyQ;

    modport slave (
        input  digValid, digCode, digMode,
        input  meraValid, meraCode, meraMode,
        input  outReady,
        output digReady, meraReady,
        output smartCode, lab, mode,
        output occupancy, isFullQ, isEmptyQ
    );

    modport master (
        output digValid, digCode, digMode,
        output meraValid, meraCode, meraMode,
        output outReady,
        input  digReady, meraReady,
        input  smartCode, lab, mode,
        input  occupancy, isFullQ, isEmptyQ
    );

endinterface

// File: rtl/lab_req_fifo.sv
// Circular-buffer FIFO of request entries. Head is read combinationally so a
// pop can register it in the same cycle; pointers wrap naturally (DEPTH is a
// power of two).
module lab_req_fifo
    import lab_request_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  entry_t                 i_wdata,
    input  logic                   i_pop,
    output entry_t                 o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lab_request_queue.sv
// Two door readers (Digital, Mera) share one request FIFO toward the access
// controller. Ties are resolved round-robin; non-request modes (1x) are
// acknowledged but discarded. Optional pop-time parity filter:
// LAB_REQ_PARITY_FILTER_EN.
module lab_request_queue
    import lab_request_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    lab_request_queue_if.slave bus
);
    // Round-robin memory: 1 when Mera was the last reader whose request was stored
    logic                   r_last_mera;
    logic [CODE_W-1:0]      r_code;
    logic                   r_lab;
    logic [1:0]             r_mode;

    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    entry_t                 w_head;
    entry_t                 w_in;
    logic                   w_grant_dig;
    logic                   w_grant_mera;
    logic                   w_xfer;
    logic                   w_store;
    logic                   w_pop;
    logic                   w_drop;

    // A lone valid reader always wins; on a tie the reader not served last wins.
    assign w_grant_dig  = bus.digValid  && (!bus.meraValid || r_last_mera);
    assign w_grant_mera = bus.meraValid && (!bus.digValid  || !r_last_mera);

    // No transfers while reset is held, and none into a full FIFO (no bypass).
    assign bus.digReady  = RST_N && !w_full && w_grant_dig;
    assign bus.meraReady = RST_N && !w_full && w_grant_mera;

    assign w_xfer  = (bus.digValid && bus.digReady) || (bus.meraValid && bus.meraReady);
    assign w_store = w_xfer && !w_in.mode[1];
    assign w_pop   = bus.outReady && !w_empty;

`ifdef LAB_REQ_PARITY_FILTER_EN
    assign w_drop = parity_drop(w_head);
`else
    assign w_drop = 1'b0;
`endif

    // Select the granted reader's fields into an entry.
    always_comb begin
        w_in.code = bus.digCode;
        w_in.lab  = LAB_DIGITAL;
        w_in.mode = bus.digMode;
        if (w_grant_mera) begin
            w_in.code = bus.meraCode;
            w_in.lab  = LAB_MERA;
            w_in.mode = bus.meraMode;
        end
    end

    lab_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_push  (w_store),
        .i_wdata (w_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Round-robin state follows only stored transfers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_mera <= LAB_MERA;
        end else if (w_store) begin
            r_last_mera <= w_grant_mera;
        end
    end

    // Output register: a popped entry is shown for one cycle, idle otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_code <= '0;
            r_lab  <= LAB_DIGITAL;
            r_mode <= MODE_IDLE;
        end else if (w_pop && !w_drop) begin
            r_code <= w_head.code;
            r_lab  <= w_head.lab;
            r_mode <= w_head.mode;
        end else begin
            r_mode <= MODE_IDLE;
        end
    end

    assign bus.smartCode = r_code;
    assign bus.lab       = r_lab;
    assign bus.mode      = r_mode;
    assign bus.occupancy = w_count;
    assign bus.isFullQ   = w_full;
    assign bus.isEmptyQ  = w_empty;

endmodule

// File: doc/lab_request_queue.md
LAB_REQUEST_QUEUE -- requirements
Module: lab_request_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..32).
REQ-002 The block SHALL have port CLK  input  1  single clock; all state changes on posedge.
REQ-003 The block SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports digValid/digReady/digCode/digMode  in/out/in/in  1/1/5/2  Digital door reader request (lab=0).
REQ-005 The block SHALL have ports meraValid/meraReady/meraCode/meraMode  in/out/in/in  1/1/5/2  Mera door reader request (lab=1).
REQ-006 The block SHALL have port outReady  input  1  downstream access controller may take a request this cycle.
REQ-007 The block SHALL have ports smartCode/lab/mode  output  5/1/2  request issued to the access controller; mode 00 = exit, 01 = enter, 10 = idle.
REQ-008 The block SHALL have port occupancy  output  $clog2(DEPTH)+1  number of stored entries.
REQ-009 The block SHALL have ports isFullQ/isEmptyQ  output  1/1  FIFO full and empty flags.

Function
REQ-010 A reader transfer SHALL occur on a posedge where its Valid and Ready are both 1.
REQ-011 Each Ready SHALL be combinational: 1 when the FIFO is not full and the arbiter grants that reader; the losing reader's Ready SHALL be 0.
REQ-012 When both readers are valid in the same cycle, the grant SHALL go round-robin to the reader not granted at the last accepted transfer; after reset Digital SHALL win the first tie.
REQ-013 When only one reader is valid, it SHALL be granted regardless of round-robin state, and the round-robin state SHALL update to it.
REQ-014 A transfer whose mode is 1x SHALL be accepted (Ready=1 if granted) but not stored, and SHALL not change round-robin state.
REQ-015 A stored entry SHALL be {code[4:0], lab, mode[1:0]}, with lab 0 for Digital and 1 for Mera.
REQ-016 The FIFO SHALL pop on a posedge where outReady=1 and it is not empty.
REQ-017 On a pop, smartCode/lab/mode SHALL load the head entry; otherwise mode SHALL load 2'b10 and smartCode/lab SHALL hold.
REQ-018 A request SHALL be presented for exactly one cycle per pop.
REQ-019 Minimum latency SHALL be 2 edges: pushed at edge k into an empty FIFO, presented after edge k+1 with outReady=1.
REQ-020 Full push: Ready SHALL be 0 when full, even if a pop occurs in the same cycle (no bypass).
REQ-021 Simultaneous push and pop when neither full nor empty: occupancy SHALL be unchanged.
REQ-022 Order SHALL be strict FIFO across both readers.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-024 isFullQ SHALL equal (occupancy==DEPTH) and isEmptyQ SHALL equal (occupancy==0), both from registered occupancy.

Reset
REQ-025 RST_N low SHALL immediately clear pointers and occupancy to 0, set isEmptyQ=1, isFullQ=0, smartCode=0, lab=0, mode=2'b10, and the round-robin state to "Mera last" (so Digital wins the first tie).
REQ-026 Reset mid-operation SHALL discard all stored entries, and no request SHALL be issued until a new push.
REQ-027 Reset deassertion SHALL take effect at the first posedge after RST_N rises; no transfer SHALL occur while RST_N is low (both Ready=0).

Configuration
REQ-028 With LAB_REQ_PARITY_FILTER_EN defined, a stored Digital enter request SHALL be dropped at pop time if popcount(code) is odd, and a Mera enter request if popcount(code) is even; the pop SHALL still consume the entry and mode SHALL output 2'b10 that cycle.
REQ-029 Without LAB_REQ_PARITY_FILTER_EN, every stored request SHALL be issued unchanged.

Structure
REQ-030 A shared package SHALL hold the mode encodings (MODE_EXIT=00, MODE_ENTER=01, MODE_IDLE=10), the lab encodings (LAB_DIGITAL=0, LAB_MERA=1), and the packed entry typedef.
REQ-031 The FIFO storage and pointers SHALL be one sub-module, lab_req_fifo; the arbiter and output register SHALL remain in the top.

Verification
REQ-032 After reset, Digital valid with code 5'b00011, mode 01, and outReady=1 -> accepted at edge 1; smartCode=00011, lab=0, mode=01 after edge 2 for one cycle, then mode=10.
REQ-033 Both readers valid for 4 cycles with outReady=0 -> grants D,M,D,M; occupancy=4; the pop order matches.
REQ-034 Digital valid continuously with outReady=0 -> 8 accepts, then digReady=0 and isFullQ=1; one pop frees exactly one slot.
REQ-035 A reader pushes mode 2'b11 -> Ready=1, occupancy unchanged, no output request.
REQ-036 RST_N pulsed low with occupancy=5 -> occupancy=0 and mode=10 immediately, with no stale request afterwards.
REQ-037 With LAB_REQ_PARITY_FILTER_EN, a Mera enter with code 5'b00011 -> popped and mode=10; with code 5'b00111 -> issued with mode=01.
